// File: rtl/music_sequencer.sv
// Score sequencer: walks a {length, note, octave} ROM on the 1 ms clock and
// counts each note down, with loop/stop, pause, skip and restart control.
module music_sequencer #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 16,
  parameter int NOTE_W = 4,
  parameter int OCT_W  = 4
) (
  input  logic                            clk_1ms,
  input  logic                            rst,
  input  logic                            en,
  input  logic                            loop_en,
  input  logic                            skip,
  input  logic                            restart,
  output logic [ADDR_W-1:0]               score_addr,
  input  logic [LEN_W+NOTE_W+OCT_W-1:0]   score_data,
  output logic [ADDR_W-1:0]               note_pointer,
  output logic [LEN_W-1:0]                cur_length,
  output logic [NOTE_W-1:0]               cur_note,
  output logic [OCT_W-1:0]                cur_octave,
  output logic                            playing,
  output logic                            note_start,
  output logic                            done
);
  localparam int WORD_W = LEN_W + NOTE_W + OCT_W;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_ptr, w_ptr_nxt;
  logic [LEN_W-1:0]    r_len, w_len_nxt;
  logic [NOTE_W-1:0]   r_note, w_note_nxt;
  logic [OCT_W-1:0]    r_oct, w_oct_nxt;
  logic                r_start, w_start_nxt;
  logic                r_done, w_done_nxt;

  logic [LEN_W-1:0]    w_len_f;
  logic [NOTE_W-1:0]   w_note_f;
  logic [OCT_W-1:0]    w_oct_f;

  assign w_len_f  = score_data[WORD_W-1 -: LEN_W];
  assign w_note_f = score_data[OCT_W +: NOTE_W];
  assign w_oct_f  = score_data[OCT_W-1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_len_nxt   = r_len;
    w_note_nxt  = r_note;
    w_oct_nxt   = r_oct;
    w_start_nxt = 1'b0;
    w_done_nxt  = r_done;
    if (restart) begin
      w_ptr_nxt   = '0;
      w_state_nxt = S_LOAD;
      w_done_nxt  = 1'b0;
    end else if (r_state != S_DONE && en) begin
      case (r_state)
        S_IDLE: w_state_nxt = S_LOAD;
        S_LOAD: begin
          if (w_len_f != '0) begin
            w_len_nxt   = w_len_f;
            w_note_nxt  = w_note_f;
            w_oct_nxt   = w_oct_f;
            w_start_nxt = 1'b1;
            w_state_nxt = S_PLAY;
          end else if (loop_en && r_ptr != '0) begin
            // Marker hit mid-score: rewind and refetch address 0 next cycle.
            w_ptr_nxt = '0;
          end else begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end
        end
        S_PLAY: begin
          if (skip || r_len == LEN_W'(1)) begin
            w_ptr_nxt   = r_ptr + ADDR_W'(1);
            w_state_nxt = S_LOAD;
          end else begin
            w_len_nxt = r_len - LEN_W'(1);
          end
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk_1ms) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_len   <= '0;
      r_note  <= '0;
      r_oct   <= '0;
      r_start <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_len   <= w_len_nxt;
      r_note  <= w_note_nxt;
      r_oct   <= w_oct_nxt;
      r_start <= w_start_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign score_addr   = r_ptr;
  assign note_pointer = r_ptr;
  assign cur_length   = r_len;
  assign cur_note     = r_note;
  assign cur_octave   = r_oct;
  assign playing      = (r_state == S_PLAY) && en;
  assign note_start   = r_start;
  assign done         = r_done;
endmodule
